serial_subtractor: RTL and testbench

//  Bit-serial N-bit subtractor: diff = a - b - bin, computed LSB first, one bit per clock.
//  It pairs with the combinational full-adder cell as the inverse operation,

---
 rtl/serial_subtractor.sv | 67 ++++++
 tb/tb_serial_subtractor.sv | 112 +++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, one bit per clock, with registered borrow
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             diff_bit,
    output logic             bit_vld
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t         state;
    logic [CW-1:0]  cnt;
    logic [WIDTH-1:0] a_sh, b_sh, r_sh;
    logic           br, d, br_nxt;
    assign d        = a_sh[0] ^ b_sh[0] ^ br;
    assign br_nxt   = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    assign busy     = state == RUN;
    assign done     = state == DONE;
    assign bit_vld  = busy;
    assign diff_bit = busy & d;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            a_sh  <= '0;
            b_sh  <= '0;
            r_sh  <= '0;
            br    <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_sh  <= a;
                    b_sh  <= b;
                    br    <= bin;
                    cnt   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    r_sh <= {d, r_sh[WIDTH-1:1]};
                    br   <= br_nxt;
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        diff  <= {d, r_sh[WIDTH-1:1]};
                        bout  <= br_nxt;
                        cnt   <= '0;
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed vectors plus abort and ignored-start sequences for serial_subtractor
module tb_serial_subtractor;
    logic       clk = 0, rst_n = 0, start = 0, bin = 0;
    logic [7:0] a = 0, b = 0;
    logic       busy, done, bout, diff_bit, bit_vld;
    logic [7:0] diff;
    int         cmp = 0, errs = 0;

    typedef struct {
        logic [7:0] a, b;
        logic       bin;
        logic [7:0] diff;
        logic       bout;
    } vec_t;
    vec_t v[8];

    serial_subtractor #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .bout(bout),
        .diff_bit(diff_bit), .bit_vld(bit_vld)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        cmp++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic op(input logic [7:0] ta, input logic [7:0] tb_, input logic tbin,
                      input logic [7:0] ed, input logic eb, input bit inject);
        logic [7:0] prev;
        string      t;
        t    = $sformatf("%02h-%02h-%0d", ta, tb_, tbin);
        prev = diff;
        a = ta; b = tb_; bin = tbin; start = 1;
        @(posedge clk); #1;
        start = 0; a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
        chk({t, " busy"}, busy, 1);
        chk({t, " diff_hold"}, diff, prev);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s diff_bit[%0d]", t, i), diff_bit, ed[i]);
            chk({t, " bit_vld"}, bit_vld, 1);
            chk({t, " done_early"}, done, 0);
            if (inject && i == 2) begin start = 1; a = 8'hFF; b = 8'h00; end
            if (inject && i == 3) start = 0;
            @(posedge clk); #1;
        end
        chk({t, " done"}, done, 1);
        chk({t, " busy_off"}, busy, 0);
        chk({t, " diff"}, diff, ed);
        chk({t, " bout"}, bout, eb);
        @(posedge clk); #1;
        chk({t, " done_pulse"}, done, 0);
        chk({t, " diff_keep"}, diff, ed);
    endtask

    initial begin
        int seen;
        v[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0};
        v[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
        v[2] = '{8'h10, 8'h10, 1'b1, 8'hFF, 1'b1};
        v[3] = '{8'h10, 8'h10, 1'b0, 8'h00, 1'b0};
        v[4] = '{8'h80, 8'h7F, 1'b0, 8'h01, 1'b0};
        v[5] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};
        v[6] = '{8'hC8, 8'h64, 1'b1, 8'h63, 1'b0};
        v[7] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        #1;
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst diff", diff, 0);
        chk("rst bout", bout, 0);
        chk("rst diff_bit", diff_bit, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
        foreach (v[k]) op(v[k].a, v[k].b, v[k].bin, v[k].diff, v[k].bout, 0);
        // abort at cnt=3; diff/bout must clear asynchronously, without waiting for an edge
        a = 8'h33; b = 8'h11; bin = 0; start = 1;
        @(posedge clk); #1;
        start = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 0;
        #1;
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort bit_vld", bit_vld, 0);
        chk("abort diff", diff, 0);
        chk("abort bout", bout, 0);
        @(negedge clk) rst_n = 1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        chk("abort no_done", seen, 0);
        op(8'hFF, 8'h01, 1'b0, 8'hFE, 1'b0, 0);
        op(8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        chk("ignored start no_extra_op", seen, 0);
        chk("ignored start diff", diff, 8'h05);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule
